// File: rtl/gamepad_pkg.sv
// Shared types and constants for the serial gamepad poller.
// frame_cycles gives the number of busy cycles of one frame (LATCH through DONE).
package gamepad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  localparam int LATCH_TICKS = 2;

  function automatic int frame_cycles(input int nb, input int div);
    return (2 + 2 * nb) * div + 1;
  endfunction

endpackage

// File: rtl/pad_tick_gen.sv
// Divides clk down to one tick every CLK_DIV cycles; tick is high on count CLK_DIV-1.
// The counter is held at zero while clear is high so a frame always starts phase-aligned.
module pad_tick_gen #(
  parameter int CLK_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (count_reg == W'(CLK_DIV - 1)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == W'(CLK_DIV - 1));

endmodule

// File: rtl/multi_pad_reader.sv
// Polls NUM_PADS serial shift-register gamepads over a shared latch/clock pair and
// publishes per-pad button words with pressed/released edge masks and a valid strobe.
module multi_pad_reader
  import gamepad_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BUTTONS = 8,
  parameter int CLK_DIV     = 100,
  parameter int POLL_PERIOD = 200000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            poll_req,
  input  logic                            auto_en,
  input  logic [NUM_PADS-1:0]             readline,
  output logic                            poll_signal,
  output logic                            pad_clk,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] buttons,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] pressed,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] released,
  output logic                            valid,
  output logic                            busy
);

  localparam int NB  = NUM_BUTTONS;
  localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW  = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam int LW  = (LATCH_TICKS > 2) ? $clog2(LATCH_TICKS) : 1;
  localparam logic INV = (ACTIVE_LOW != 0);

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [LW-1:0]   latch_cnt_reg, latch_cnt_next;
  logic [PW-1:0]   period_reg;
  logic            pending_reg, pending_next;
  logic            tick;
  logic            period_evt;
  logic            request;
  logic            last_bit;
  logic [NUM_PADS*NB-1:0] shreg_all;

  pad_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state_reg == IDLE),
    .tick  (tick)
  );

  assign period_evt = auto_en && (period_reg == PW'(POLL_PERIOD - 1));
  assign request    = poll_req || period_evt;
  assign last_bit   = (idx_reg == IW'(NB - 1));

  always_ff @(posedge clk) begin
    if (reset || !auto_en) begin
      period_reg <= '0;
    end else if (period_evt) begin
      period_reg <= '0;
    end else begin
      period_reg <= period_reg + 1'b1;
    end
  end

  // A request arriving in the same cycle the frame starts stays pending.
  always_comb begin
    pending_next = pending_reg || request;
    if (state_reg == IDLE && pending_reg) begin
      pending_next = request;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    latch_cnt_next = latch_cnt_reg;
    unique case (state_reg)
      IDLE: begin
        latch_cnt_next = '0;
        if (pending_reg) state_next = LATCH;
      end
      LATCH: begin
        if (tick) begin
          if (latch_cnt_reg == LW'(LATCH_TICKS - 1)) begin
            state_next = SHIFT_LO;
            idx_next   = '0;
          end else begin
            latch_cnt_next = latch_cnt_reg + 1'b1;
          end
        end
      end
      SHIFT_LO: begin
        if (tick) state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick) begin
          if (last_bit) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = SHIFT_LO;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      latch_cnt_reg <= '0;
      pending_reg   <= 1'b0;
      poll_signal   <= 1'b0;
      pad_clk       <= 1'b0;
      valid         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      latch_cnt_reg <= latch_cnt_next;
      pending_reg   <= pending_next;
      poll_signal   <= (state_next == LATCH);
      pad_clk       <= (state_next == SHIFT_HI);
      valid         <= (state_next == DONE);
      busy          <= (state_next != IDLE);
    end
  end

  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
    logic [NB-1:0] shreg;
    always_ff @(posedge clk) begin
      if (reset) begin
        shreg <= '0;
      end else if (state_reg == SHIFT_LO && tick) begin
        shreg[idx_reg] <= readline[gi] ^ INV;
      end
    end
    assign shreg_all[gi*NB +: NB] = shreg;
  end

  // Publish on the edge into DONE so the words are stable while valid is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      buttons  <= '0;
      pressed  <= '0;
      released <= '0;
    end else if (state_reg == SHIFT_HI && tick && last_bit) begin
      buttons  <= shreg_all;
      pressed  <= shreg_all & ~buttons;
      released <= ~shreg_all & buttons;
    end
  end

endmodule

// File: tb/tb_multi_pad_reader.sv
// Directed bench for multi_pad_reader: a two-pad instance with a behavioural pad model
// and a single-button active-high instance.
module tb_multi_pad_reader;
  import gamepad_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic        reset = 1'b1;
  logic        poll_req = 1'b0;
  logic        auto_en = 1'b0;
  logic [1:0]  readline;
  logic        poll_signal, pad_clk, valid, busy;
  logic [15:0] buttons, pressed, released;

  logic        poll_req_b = 1'b0;
  logic        auto_en_b = 1'b0;
  logic [0:0]  readline_b = 1'b1;
  logic        poll_b, pad_clk_b, valid_b, busy_b;
  logic [0:0]  buttons_b, pressed_b, released_b;

  multi_pad_reader #(.NUM_PADS(2), .NUM_BUTTONS(8), .CLK_DIV(4), .POLL_PERIOD(100),
                     .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .reset(reset), .poll_req(poll_req), .auto_en(auto_en), .readline(readline),
    .poll_signal(poll_signal), .pad_clk(pad_clk), .buttons(buttons), .pressed(pressed),
    .released(released), .valid(valid), .busy(busy));

  multi_pad_reader #(.NUM_PADS(1), .NUM_BUTTONS(1), .CLK_DIV(4), .POLL_PERIOD(1000),
                     .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .reset(reset), .poll_req(poll_req_b), .auto_en(auto_en_b), .readline(readline_b),
    .poll_signal(poll_b), .pad_clk(pad_clk_b), .buttons(buttons_b), .pressed(pressed_b),
    .released(released_b), .valid(valid_b), .busy(busy_b));

  // Pad model: latch reloads, each pad_clk rising edge advances to the next bit.
  logic [7:0] pad_data [2];
  int   sh_cnt = 0;
  logic pc_d = 1'b0;
  always @(posedge clk) begin
    pc_d <= pad_clk;
    if (poll_signal) sh_cnt <= 0;
    else if (pad_clk && !pc_d) sh_cnt <= sh_cnt + 1;
  end
  always @* begin
    for (int p = 0; p < 2; p++) begin
      readline[p] = (sh_cnt < 8) ? ~pad_data[p][sh_cnt[2:0]] : 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Pulse poll_req on instance A and wait for valid; returns latency and busy cycles.
  task automatic poll_a(output int lat, output int busy_cyc);
    int t0;
    @(negedge clk) poll_req = 1'b1;
    t0 = cyc;
    @(negedge clk) poll_req = 1'b0;
    lat = -1;
    busy_cyc = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy) busy_cyc++;
      if (valid) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, bc, nvalid, first_rel, t0, npc;
    int rises [3];
    int nrise, poll_hi, pclk_rises, pclk_hi;
    logic prev_poll, prev_pc;

    pad_data[0] = 8'h5A;
    pad_data[1] = 8'hC3;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_poll", poll_signal, 0);
    check("rst_pclk", pad_clk, 0);
    check("rst_outs", {buttons, pressed, released}, 0);
    check("rst_valid_busy", {valid, busy}, 0);

    // First frame compares against all-zero buttons
    poll_a(lat, bc);
    check("f1_latency", lat, 74);
    check("f1_busy_cycles", bc, frame_cycles(8, 4));
    check("f1_buttons", buttons, 16'hC35A);
    check("f1_pressed", pressed, 16'hC35A);
    check("f1_released", released, 16'h0000);
    @(negedge clk);
    check("f1_valid_1cyc", valid, 0);

    // Single-bit change on pad 0
    pad_data[0] = 8'h5B;
    poll_a(lat, bc);
    check("f2_buttons", buttons, 16'hC35B);
    check("f2_pressed", pressed, 16'h0001);
    check("f2_released", released, 16'h0000);
    repeat (5) @(negedge clk);
    check("f2_masks_hold", {pressed, released}, {16'h0001, 16'h0000});

    // Requests during a frame merge into exactly one follow-up frame
    pad_data[1] = 8'h00;
    nvalid = 0;
    first_rel = -1;
    @(negedge clk) poll_req = 1'b1;
    @(negedge clk) poll_req = 1'b0;
    for (int i = 0; i < 220; i++) begin
      if (i == 10 || i == 30 || i == 50) poll_req = 1'b1;
      else poll_req = 1'b0;
      if (valid) begin
        nvalid++;
        if (first_rel < 0) first_rel = int'(released);
      end
      @(negedge clk);
    end
    poll_req = 1'b0;
    check("merge_frames", nvalid, 2);
    check("merge_rel_first", first_rel, 32'h0000C300);
    check("merge_rel_last", released, 16'h0000);
    check("merge_buttons", buttons, 16'h005B);
    check("merge_idle_busy", busy, 0);

    // Periodic polling
    nrise = 0; poll_hi = 0; pclk_rises = 0; pclk_hi = 0;
    prev_poll = 1'b0; prev_pc = 1'b0;
    @(negedge clk) auto_en = 1'b1;
    for (int i = 0; i < 400 && nrise < 3; i++) begin
      @(negedge clk);
      if (poll_signal && !prev_poll) begin
        rises[nrise] = cyc;
        nrise++;
      end
      if (nrise == 1) begin
        if (poll_signal) poll_hi++;
        if (pad_clk && !prev_pc) pclk_rises++;
        if (pad_clk) pclk_hi++;
      end
      prev_poll = poll_signal;
      prev_pc = pad_clk;
    end
    auto_en = 1'b0;
    check("auto_rises", nrise, 3);
    check("auto_period_1", rises[1] - rises[0], 100);
    check("auto_period_2", rises[2] - rises[1], 100);
    check("auto_latch_len", poll_hi, 8);
    check("auto_pclk_pulses", pclk_rises, 8);
    check("auto_pclk_high", pclk_hi, 32);
    repeat (100) @(negedge clk);
    check("auto_off_idle", busy, 0);

    // Reset during the shift phase aborts the frame
    pad_data[0] = 8'h5A;
    pad_data[1] = 8'hC3;
    @(negedge clk) poll_req = 1'b1;
    @(negedge clk) poll_req = 1'b0;
    npc = 0; prev_pc = 1'b0;
    for (int i = 0; i < 200 && npc < 4; i++) begin
      @(negedge clk);
      if (pad_clk && !prev_pc) npc++;
      prev_pc = pad_clk;
    end
    check("mid_reach_idx3", npc, 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_pins", {poll_signal, pad_clk, busy, valid}, 0);
    check("mid_rst_buttons", buttons, 0);
    nvalid = 0;
    repeat (100) begin
      @(negedge clk);
      if (valid || busy) nvalid++;
    end
    check("mid_rst_no_frame", nvalid, 0);
    poll_a(lat, bc);
    check("mid_new_latency", lat, 74);
    check("mid_new_buttons", buttons, 16'hC35A);
    check("mid_new_pressed", pressed, 16'hC35A);

    // Single-button, active-high instance
    npc = 0; prev_pc = 1'b0; bc = 0; lat = -1;
    @(negedge clk) poll_req_b = 1'b1;
    t0 = cyc;
    @(negedge clk) poll_req_b = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy_b) bc++;
      if (pad_clk_b && !prev_pc) npc++;
      prev_pc = pad_clk_b;
      if (valid_b) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    check("nb1_latency", lat, 18);
    check("nb1_busy_cycles", bc, frame_cycles(1, 4));
    check("nb1_buttons", buttons_b, 1);
    check("nb1_pressed", pressed_b, 1);
    check("nb1_pclk_pulses", npc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
